// File: rtl/snitch_hwpe_pkg.sv
// snitch_hwpe_pkg: request-type enum, default outstanding limit and default reqrsp TCDM structs for the HWPE bridge
package snitch_hwpe_pkg;
  localparam int unsigned DefaultMaxOutstanding = 4;
  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 64;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_e;
  typedef enum logic [3:0] {
    AMONone, AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
    AMOMax, AMOMaxu, AMOMin, AMOMinu, AMOLR, AMOSC
  } amo_op_e;
  typedef struct packed {
    logic [4:0] core_id;
    logic       is_core;
  } tcdm_user_t;
  typedef struct packed {
    logic [DefaultAddrWidth-1:0]   addr;
    logic                          write;
    amo_op_e                       amo;
    logic [DefaultDataWidth-1:0]   data;
    logic [DefaultDataWidth/8-1:0] strb;
    tcdm_user_t                    user;
  } tcdm_req_chan_t;
  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } hwpe_tcdm_req_t;
  typedef struct packed {
    logic [DefaultDataWidth-1:0] data;
  } tcdm_rsp_chan_t;
  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } hwpe_tcdm_rsp_t;
endpackage

// File: rtl/snitch_hwpe_tcdm_port.sv
// snitch_hwpe_tcdm_port: one HWPE port (req/gnt/add/wen/be/wdata in, r_data/r_valid out, tcdm req/rsp, busy, sticky err) with credit counter and in-order type FIFO
module snitch_hwpe_tcdm_port
  import snitch_hwpe_pkg::*;
#(
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter bit          DropWriteRsp   = 1'b1,
  parameter int unsigned AddrWidth      = DefaultAddrWidth,
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter type         tcdm_req_t     = hwpe_tcdm_req_t,
  parameter type         tcdm_rsp_t     = hwpe_tcdm_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req,
  output logic                   gnt,
  input  logic [31:0]            add,
  input  logic                   wen,
  input  logic [DataWidth/8-1:0] be,
  input  logic [DataWidth-1:0]   wdata,
  output logic [DataWidth-1:0]   r_data,
  output logic                   r_valid,
  output tcdm_req_t              tcdm_req,
  input  tcdm_rsp_t              tcdm_rsp,
  output logic                   busy,
  output logic                   err
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  logic [CntW-1:0] cnt;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  req_type_e fifo [MaxOutstanding];
  logic credit_ok, push, pop;
  always_comb begin
    credit_ok = cnt < MaxCnt;
    push = req & credit_ok & tcdm_rsp.q_ready;
    pop = tcdm_rsp.p_valid & (cnt != '0);
    tcdm_req = '0;
    tcdm_req.q_valid = req & credit_ok;
    tcdm_req.q.addr = add[AddrWidth-1:0];
    tcdm_req.q.write = ~wen;
    tcdm_req.q.strb = be;
    tcdm_req.q.data = wdata;
    tcdm_req.q.amo = AMONone;
    gnt = tcdm_rsp.q_ready & credit_ok;
    r_valid = pop & ~(DropWriteRsp & (fifo[rd_ptr] == WRITE));
    r_data = tcdm_rsp.p.data;
    busy = cnt != '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err <= 1'b0;
    end else begin
      if (push) fifo[wr_ptr] <= wen ? READ : WRITE;
      if (push) wr_ptr <= wr_ptr == LastPtr ? '0 : wr_ptr + PtrW'(1);
      if (pop) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + PtrW'(1);
      if (push != pop) cnt <= push ? cnt + CntW'(1) : cnt - CntW'(1);
      if (tcdm_rsp.p_valid && cnt == '0) err <= 1'b1;
    end
  end
endmodule

// File: rtl/snitch_hwpe_tcdm_bridge.sv
// snitch_hwpe_tcdm_bridge: NrPorts independent HWPE-to-TCDM ports (hwpe_* in/out, tcdm_req_o/tcdm_rsp_i per port), busy_o = any port outstanding, err_o = per-port spurious response
module snitch_hwpe_tcdm_bridge
  import snitch_hwpe_pkg::*;
#(
  parameter int unsigned NrPorts        = 16,
  parameter int unsigned AddrWidth      = DefaultAddrWidth,
  parameter int unsigned DataWidth      = DefaultDataWidth,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter bit          DropWriteRsp   = 1'b1,
  parameter type         tcdm_req_t     = hwpe_tcdm_req_t,
  parameter type         tcdm_rsp_t     = hwpe_tcdm_rsp_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrPorts-1:0]                   hwpe_req_i,
  output logic [NrPorts-1:0]                   hwpe_gnt_o,
  input  logic [NrPorts-1:0][31:0]             hwpe_add_i,
  input  logic [NrPorts-1:0]                   hwpe_wen_i,
  input  logic [NrPorts-1:0][DataWidth/8-1:0]  hwpe_be_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]    hwpe_data_i,
  output logic [NrPorts-1:0][DataWidth-1:0]    hwpe_r_data_o,
  output logic [NrPorts-1:0]                   hwpe_r_valid_o,
  output tcdm_req_t                            tcdm_req_o [NrPorts],
  input  tcdm_rsp_t                            tcdm_rsp_i [NrPorts],
  output logic                                 busy_o,
  output logic [NrPorts-1:0]                   err_o
);
  logic [NrPorts-1:0] busy;
  for (genvar i = 0; i < NrPorts; i++) begin : g_port
    snitch_hwpe_tcdm_port #(
      .MaxOutstanding(MaxOutstanding),
      .DropWriteRsp  (DropWriteRsp),
      .AddrWidth     (AddrWidth),
      .DataWidth     (DataWidth),
      .tcdm_req_t    (tcdm_req_t),
      .tcdm_rsp_t    (tcdm_rsp_t)
    ) u_port (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (hwpe_req_i[i]),
      .gnt     (hwpe_gnt_o[i]),
      .add     (hwpe_add_i[i]),
      .wen     (hwpe_wen_i[i]),
      .be      (hwpe_be_i[i]),
      .wdata   (hwpe_data_i[i]),
      .r_data  (hwpe_r_data_o[i]),
      .r_valid (hwpe_r_valid_o[i]),
      .tcdm_req(tcdm_req_o[i]),
      .tcdm_rsp(tcdm_rsp_i[i]),
      .busy    (busy[i]),
      .err     (err_o[i])
    );
  end
  assign busy_o = |busy;
endmodule

// File: tb/tb_snitch_hwpe_tcdm_bridge.sv
// tb_snitch_hwpe_tcdm_bridge: directed and random checks of the bridge against a queue-based reference model
module tb_snitch_hwpe_tcdm_bridge;
  import snitch_hwpe_pkg::*;
  localparam int N = 16;
  localparam int MO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req, gnt, wen, r_valid, err;
  logic [N-1:0][31:0] add;
  logic [N-1:0][7:0] be;
  logic [N-1:0][63:0] wdata, r_data;
  hwpe_tcdm_req_t tq [N];
  hwpe_tcdm_rsp_t tr [N];
  logic busy;
  logic b_req, b_gnt, b_wen, b_rv, b_err, b_busy;
  logic [31:0] b_add;
  logic [7:0] b_be;
  logic [63:0] b_wd, b_rd;
  hwpe_tcdm_req_t b_tq [1];
  hwpe_tcdm_rsp_t b_tr [1];
  int total = 0;
  int passes = 0;
  bit wq [N][$];
  bit err_m [N];
  always #5 clk = ~clk;
  snitch_hwpe_tcdm_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .hwpe_req_i(req), .hwpe_gnt_o(gnt), .hwpe_add_i(add),
    .hwpe_wen_i(wen), .hwpe_be_i(be), .hwpe_data_i(wdata), .hwpe_r_data_o(r_data),
    .hwpe_r_valid_o(r_valid), .tcdm_req_o(tq), .tcdm_rsp_i(tr), .busy_o(busy), .err_o(err)
  );
  snitch_hwpe_tcdm_bridge #(.NrPorts(1), .DropWriteRsp(1'b0)) dut_keep (
    .clk_i(clk), .rst_ni(rst_n), .hwpe_req_i(b_req), .hwpe_gnt_o(b_gnt), .hwpe_add_i(b_add),
    .hwpe_wen_i(b_wen), .hwpe_be_i(b_be), .hwpe_data_i(b_wd), .hwpe_r_data_o(b_rd),
    .hwpe_r_valid_o(b_rv), .tcdm_req_o(b_tq), .tcdm_rsp_i(b_tr), .busy_o(b_busy), .err_o(b_err)
  );
  task automatic chk(string tag, int p, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) passes++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, p, o, e);
  endtask
  task automatic idle();
    req = '0;
    wen = '1;
    add = '0;
    be = '0;
    wdata = '0;
    for (int p = 0; p < N; p++) begin
      tr[p] = '0;
      tr[p].q_ready = 1'b1;
    end
  endtask
  task automatic b_idle();
    b_req = 1'b0;
    b_wen = 1'b1;
    b_add = '0;
    b_be = '0;
    b_wd = '0;
    b_tr[0] = '0;
    b_tr[0].q_ready = 1'b1;
  endtask
  task automatic look();
    logic busy_e;
    #2;
    busy_e = 1'b0;
    for (int p = 0; p < N; p++) begin
      int sz;
      sz = wq[p].size();
      busy_e = busy_e | (sz != 0);
      chk("q_valid", p, tq[p].q_valid, req[p] && sz < MO);
      chk("gnt", p, gnt[p], tr[p].q_ready && sz < MO);
      chk("addr", p, tq[p].q.addr, add[p]);
      chk("write", p, tq[p].q.write, !wen[p]);
      chk("strb", p, tq[p].q.strb, be[p]);
      chk("wdata", p, tq[p].q.data, wdata[p]);
      chk("amo", p, tq[p].q.amo, AMONone);
      chk("user", p, tq[p].q.user, 0);
      chk("r_valid", p, r_valid[p], tr[p].p_valid && sz > 0 && !wq[p][0]);
      chk("r_data", p, r_data[p], tr[p].p.data);
      chk("err", p, err[p], err_m[p]);
    end
    chk("busy", 0, busy, busy_e);
  endtask
  task automatic step();
    @(posedge clk);
    for (int p = 0; p < N; p++) begin
      int sz;
      sz = wq[p].size();
      if (!rst_n) begin
        wq[p].delete();
        err_m[p] = 1'b0;
      end else begin
        if (tr[p].p_valid) begin
          if (sz > 0) void'(wq[p].pop_front());
          else err_m[p] = 1'b1;
        end
        if (req[p] && tr[p].q_ready && sz < MO) wq[p].push_back(!wen[p]);
      end
    end
    #1;
  endtask
  initial begin
    idle();
    b_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    look();
    chk("rst_busy", 0, busy, 0);
    chk("rst_err", 0, err, 0);
    chk("rst_gnt", 0, gnt, 16'hFFFF);
    req[0] = 1'b1;
    add[0] = 32'h100;
    look();
    chk("rd_qvalid", 0, tq[0].q_valid, 1);
    chk("rd_addr", 0, tq[0].q.addr, 32'h100);
    chk("rd_write", 0, tq[0].q.write, 0);
    step();
    req[0] = 1'b0;
    tr[0].p_valid = 1'b1;
    tr[0].p.data = 64'hDEADBEEF;
    look();
    chk("rd_busy1", 0, busy, 1);
    chk("rd_rvalid", 0, r_valid[0], 1);
    chk("rd_rdata", 0, r_data[0], 64'hDEADBEEF);
    step();
    tr[0].p_valid = 1'b0;
    look();
    chk("rd_busy0", 0, busy, 0);
    req[0] = 1'b1;
    wen[0] = 1'b0;
    be[0] = 8'hFF;
    wdata[0] = 64'h1234;
    b_req = 1'b1;
    b_wen = 1'b0;
    b_be = 8'hFF;
    b_wd = 64'h1234;
    look();
    chk("wr_write", 0, tq[0].q.write, 1);
    chk("wr_strb", 0, tq[0].q.strb, 8'hFF);
    chk("wr_keep_write", 0, b_tq[0].q.write, 1);
    step();
    idle();
    b_idle();
    tr[0].p_valid = 1'b1;
    b_tr[0].p_valid = 1'b1;
    look();
    chk("wr_drop_rvalid", 0, r_valid[0], 0);
    chk("wr_keep_rvalid", 0, b_rv, 1);
    step();
    idle();
    b_idle();
    req[0] = 1'b1;
    for (int i = 0; i < MO; i++) begin
      add[0] = 32'(i * 8);
      look();
      chk("cr_gnt", i, gnt[0], 1);
      step();
    end
    look();
    chk("cr_full_gnt", 0, gnt[0], 0);
    chk("cr_full_qv", 0, tq[0].q_valid, 0);
    tr[0].p_valid = 1'b1;
    look();
    chk("cr_nocomb_gnt", 0, gnt[0], 0);
    step();
    tr[0].p_valid = 1'b0;
    look();
    chk("cr_reopen_gnt", 0, gnt[0], 1);
    step();
    req[0] = 1'b0;
    tr[0].p_valid = 1'b1;
    repeat (MO) begin
      look();
      step();
    end
    idle();
    req[0] = 1'b1;
    repeat (2) begin
      look();
      step();
    end
    tr[0].p_valid = 1'b1;
    look();
    step();
    tr[0].p_valid = 1'b0;
    look();
    chk("sim_gnt1", 0, gnt[0], 1);
    step();
    look();
    chk("sim_gnt2", 0, gnt[0], 1);
    step();
    look();
    chk("sim_full", 0, gnt[0], 0);
    req[0] = 1'b0;
    tr[0].p_valid = 1'b1;
    repeat (MO) begin
      look();
      step();
    end
    idle();
    req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wen[0] = (i != 1);
      look();
      step();
    end
    req[0] = 1'b0;
    tr[0].p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("mix_rvalid", i, r_valid[0], i != 1);
      step();
    end
    idle();
    tr[3].p_valid = 1'b1;
    look();
    chk("spur_rvalid", 3, r_valid[3], 0);
    step();
    tr[3].p_valid = 1'b0;
    look();
    chk("spur_err", 3, err[3], 1);
    step();
    look();
    chk("spur_sticky", 3, err[3], 1);
    req[0] = 1'b1;
    req[1] = 1'b1;
    step();
    look();
    chk("mid_busy", 0, busy, 1);
    rst_n = 1'b0;
    look();
    step();
    rst_n = 1'b1;
    req = '0;
    look();
    chk("mid_rst_busy", 0, busy, 0);
    chk("mid_rst_err", 0, err, 0);
    repeat (300) begin
      rst_n = ($urandom_range(99) != 0);
      for (int p = 0; p < N; p++) begin
        req[p] = 1'($urandom);
        wen[p] = 1'($urandom);
        add[p] = $urandom;
        be[p] = 8'($urandom);
        wdata[p] = {$urandom, $urandom};
        tr[p].q_ready = ($urandom_range(3) != 0);
        tr[p].p_valid = ($urandom_range(2) == 0);
        tr[p].p.data = {$urandom, $urandom};
      end
      look();
      step();
    end
    rst_n = 1'b1;
    idle();
    look();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
